// File: rtl/zjh_jk_tester.sv
// zjh_jk_tester: drives a 74HC112-style JK flip-flop through a fixed 16-step vector sequence and checks Q/Qn
module zjh_jk_tester #(
    parameter int CLK_DIV = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    output logic       Dut_Set_N,
    output logic       Dut_Rst_N,
    output logic       Dut_Clk_N,
    output logic       Dut_J,
    output logic       Dut_K,
    input  logic       Dut_Q,
    input  logic       Dut_Qn,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [4:0] Err_Cnt,
    output logic [3:0] Fail_Step
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;
    // {Set_N, Rst_N, J, K} per step, step 0 in the low nibble
    localparam logic [63:0] VECS = {4'hC, 4'hF, 4'hE, 4'hE, 4'hD, 4'hF, 4'hF, 4'hF,
                                    4'hC, 4'hD, 4'hC, 4'hE, 4'h8, 4'h0, 4'h4, 4'h8};
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    state_t     r_state;
    logic [7:0] r_div;
    logic [3:0] r_step;
    logic       r_set_n, r_rst_n, r_clk_n, r_j, r_k;
    logic       r_exp_q, r_exp_qn;
    logic       r_busy, r_done, r_pass;
    logic [4:0] r_err;
    logic [3:0] r_fail;
    logic       w_div_end, w_mis, w_jk_q;
    logic [3:0] w_nstep, w_nvec;
    logic [4:0] w_err_nx;
    assign w_div_end = r_div == DIV_LAST;
    assign w_nstep   = r_step + 4'd1;
    assign w_nvec    = VECS[{w_nstep, 2'b00} +: 4];
    assign w_mis     = (Dut_Q != r_exp_q) || (Dut_Qn != r_exp_qn);
    assign w_jk_q    = (r_j & ~r_exp_q) | (~r_k & r_exp_q);
    assign w_err_nx  = r_err + {4'd0, w_mis && (r_err != 5'd16)};
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_step  <= '0;
            {r_set_n, r_rst_n, r_clk_n, r_j, r_k} <= 5'b11100;
            r_exp_q  <= 1'b0;
            r_exp_qn <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_state <= HIGH;
                    r_div   <= '0;
                    r_step  <= '0;
                    r_err   <= '0;
                    r_fail  <= '0;
                    r_pass  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_clk_n <= 1'b1;
                    {r_set_n, r_rst_n, r_j, r_k} <= VECS[3:0];
                end
                HIGH: if (w_div_end) begin
                    r_state <= LOW;
                    r_div   <= '0;
                    r_clk_n <= 1'b0;
                    // reference flip-flop advances on the same falling edge as the real one
                    r_exp_q  <= !r_set_n ? 1'b1 : !r_rst_n ? 1'b0 : w_jk_q;
                    r_exp_qn <= !r_rst_n ? 1'b1 : !r_set_n ? 1'b0 : ~w_jk_q;
                end else begin
                    r_div <= r_div + 8'd1;
                end
                LOW: if (w_div_end) begin
                    r_err   <= w_err_nx;
                    r_div   <= '0;
                    r_clk_n <= 1'b1;
                    if (w_mis && r_err == 5'd0)
                        r_fail <= r_step;
                    if (r_step == 4'd15) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_err_nx == 5'd0;
                        {r_set_n, r_rst_n, r_j, r_k} <= 4'b1100;
                    end else begin
                        r_state <= HIGH;
                        r_step  <= w_nstep;
                        {r_set_n, r_rst_n, r_j, r_k} <= w_nvec;
                    end
                end else begin
                    r_div <= r_div + 8'd1;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign Dut_Set_N = r_set_n;
    assign Dut_Rst_N = r_rst_n;
    assign Dut_Clk_N = r_clk_n;
    assign Dut_J     = r_j;
    assign Dut_K     = r_k;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Pass      = r_pass;
    assign Err_Cnt   = r_err;
    assign Fail_Step = r_fail;
endmodule

// File: tb/tb_zjh_jk_tester.sv
// tb_zjh_jk_tester: tester instances at CLK_DIV 4 and 2, each wired to a behavioural 74HC112 with optional faults
module tb_zjh_jk_tester;
    // spec vector table, bit i = step i
    localparam logic [15:0] SN_T  = 16'hFFF9;
    localparam logic [15:0] RN_T  = 16'hFFF2;
    localparam logic [15:0] J_T   = 16'h7710;
    localparam logic [15:0] K_T   = 16'h4F40;
    localparam logic [15:0] QE_T  = 16'h3536;
    localparam logic [15:0] QNE_T = 16'hCACD;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] set_n, rst_n, clk_n, j, k, q, qn, busy, done, pass;
    logic [1:0][4:0] err_cnt;
    logic [1:0][3:0] fail_step;
    int fault [2] = '{0, 0};
    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    always #5 clk = ~clk;
    always @(negedge clk) if (done[0]) n_done++;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic q_int = 1'b0;
        logic last_clk = 1'b1;
        // fault 1: Q stuck low; fault 2: K input ignored
        always @(clk_n[g], set_n[g], rst_n[g]) begin
            if (!rst_n[g]) q_int = 1'b0;
            else if (!set_n[g]) q_int = 1'b1;
            else if (!clk_n[g] && last_clk)
                q_int = (j[g] & ~q_int) | (~(k[g] && fault[g] != 2) & q_int);
            last_clk = clk_n[g];
        end
        assign q[g]  = (fault[g] == 1) ? 1'b0 : (!set_n[g] | q_int);
        assign qn[g] = !rst_n[g] | ~q_int;
        zjh_jk_tester #(.CLK_DIV(g == 0 ? 4 : 2)) u_dut (
            .Clk(clk), .Rst(rst), .Start(start[g]),
            .Dut_Set_N(set_n[g]), .Dut_Rst_N(rst_n[g]), .Dut_Clk_N(clk_n[g]),
            .Dut_J(j[g]), .Dut_K(k[g]), .Dut_Q(q[g]), .Dut_Qn(qn[g]),
            .Busy(busy[g]), .Done(done[g]), .Pass(pass[g]),
            .Err_Cnt(err_cnt[g]), .Fail_Step(fail_step[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // expected tester verdict: play the table through the (possibly faulty) flip-flop
    function automatic void model(input int f, output int ne, output int fs);
        logic [15:0] sn = SN_T, rn = RN_T, jt = J_T, kt = K_T, qe = QE_T, qne = QNE_T;
        logic fq = 1'b0;
        logic qo, qno;
        ne = 0;
        fs = 0;
        for (int i = 0; i < 16; i++) begin
            if (!rn[i]) fq = 1'b0;
            else if (!sn[i]) fq = 1'b1;
            else fq = (jt[i] & ~fq) | (~(kt[i] && f != 2) & fq);
            qo  = (f == 1) ? 1'b0 : (!sn[i] | fq);
            qno = !rn[i] | ~fq;
            if (qo != qe[i] || qno != qne[i]) begin
                if (ne == 0) fs = i;
                ne++;
            end
        end
    endfunction
    task automatic run4(input int f, input bit extra);
        int cyc, nd0, e_err, e_fail;
        model(f, e_err, e_fail);
        fault[0] = f;
        nd0 = n_done;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 1;
        chk("busy_rise", busy[0], 1);
        while (!done[0] && cyc < 300) begin
            start[0] = extra && (cyc % 37 == 5);
            @(negedge clk);
            cyc++;
        end
        start[0] = extra;
        chk("done_lat", cyc, 129);
        chk("busy_at_done", busy[0], 0);
        chk("pass", pass[0], e_err == 0);
        chk("err_cnt", err_cnt[0], e_err);
        chk("fail_step", fail_step[0], e_fail);
        @(negedge clk);
        start[0] = 1'b0;
        chk("done_width", done[0], 0);
        chk("done_once", n_done - nd0, 1);
        chk("idle_busy", busy[0], 0);
        chk("idle_vec", {set_n[0], rst_n[0], clk_n[0], j[0], k[0]}, 5'b11100);
    endtask
    task automatic run2();
        logic [3:0] vh [100];
        logic ch [100];
        int dl, nf, last;
        logic ok;
        dl = 0;
        nf = 0;
        last = 0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int i = 1; i < 100; i++) begin
            ch[i] = clk_n[1];
            vh[i] = {set_n[1], rst_n[1], j[1], k[1]};
            if (done[1] && dl == 0) dl = i;
            @(negedge clk);
        end
        chk("div2_done_lat", dl, 65);
        chk("div2_pass", pass[1], 1);
        for (int t = 3; t < 98; t++) begin
            if (!ch[t] && ch[t-1]) begin
                nf++;
                if (last != 0) chk("div2_period", t - last, 4);
                ok = (vh[t-2] == vh[t]) && (vh[t-1] == vh[t]) && (vh[t+1] == vh[t]);
                chk("div2_stable", ok, 1);
                last = t;
            end
        end
        chk("div2_falls", nf, 16);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        int nd0;
        repeat (3) @(negedge clk);
        chk("rst_vec", {set_n[0], rst_n[0], clk_n[0], j[0], k[0]}, 5'b11100);
        chk("rst_stat", {busy[0], done[0], pass[0], err_cnt[0], fail_step[0]}, 0);
        rst = 1'b0;
        @(negedge clk);
        run4(0, 1'b0);
        run4(1, 1'b0);
        run4(2, 1'b0);
        run4(0, 1'b1);
        run2();
        fault[0] = 1;
        nd0 = n_done;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (61) @(negedge clk);
        chk("mid_busy", busy[0], 1);
        chk("mid_errs", err_cnt[0], 4);
        rst = 1'b1;
        #1;
        chk("abort_vec", {set_n[0], rst_n[0], clk_n[0], j[0], k[0]}, 5'b11100);
        chk("abort_stat", {busy[0], done[0], pass[0], err_cnt[0], fail_step[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_no_done", n_done - nd0, 0);
        run4(0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run4(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/zjh_jk_tester.md
# zjh_jk_tester

Self-checking stimulus generator and checker for the 74HC112-style negative-edge JK flip-flop with active-low preset and clear. It drives the flip-flop's Set_N, Rst_N, Clk_N, J and K pins from a fixed 16-step vector sequence and samples Q and Qn back. It compares them against an internal reference model and reports pass/fail, error count and first failing step. It sits on the board-test side of the flip-flop, at the other end of that pin interface.

## Interface
- CLK_DIV, 4, system clocks per half-period of the generated Clk_N; legal range 2..255
- Clk  input  1  system clock; all logic on rising edge
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle request to run the sequence; ignored while Busy=1
- Dut_Set_N  output  1  to flip-flop Set_N (active-low preset)
- Dut_Rst_N  output  1  to flip-flop Rst_N (active-low clear)
- Dut_Clk_N  output  1  to flip-flop clock; the flip-flop's active edge is falling
- Dut_J  output  1  to flip-flop J
- Dut_K  output  1  to flip-flop K
- Dut_Q  input  1  from flip-flop Q
- Dut_Qn  input  1  from flip-flop Qn
- Busy  output  1  high from the cycle after Start until Done
- Done  output  1  one-cycle pulse at end of run
- Pass  output  1  high when the last run had zero mismatches; held until next accepted Start
- Err_Cnt  output  5  mismatching steps in the last run (0..16)
- Fail_Step  output  4  index of the first mismatching step; 0 when Pass=1

## Operation
- The design is a single clock domain. Dut_Q and Dut_Qn are sampled directly, with no synchronizer, because the flip-flop is driven only from this block's registered outputs.
- The FSM has four states: IDLE, HIGH, LOW and FINISH. A divider counter runs 0..CLK_DIV-1 and a step counter runs 0..15.
- IDLE to HIGH on Start. On that transition:
  - Step, Err_Cnt, Fail_Step and Pass are cleared.
  - The step-0 vector is driven.
- HIGH: Dut_Clk_N=1 and the step vector is held for CLK_DIV cycles, then the FSM goes to LOW.
- LOW: Dut_Clk_N=0, which makes the falling edge on entry. The vector is held for CLK_DIV cycles.
- Sampling happens in the last LOW cycle (divider = CLK_DIV-1):
  - Dut_Q and Dut_Qn are compared with the expected values.
  - On a mismatch, Err_Cnt increments. If this is the first mismatch, Fail_Step takes the step index.
- After sampling:
  - If step < 15: the step counter increments, the next vector is driven and the FSM goes to HIGH.
  - If step = 15: the FSM goes to FINISH.
- FINISH (one cycle): Done=1, Pass=(Err_Cnt==0), Busy=0, then the FSM returns to IDLE. In idle, all Dut outputs return to their reset values.
- Vector table, given as step: Set_N Rst_N J K -> expected Q Qn:
  - Asynchronous steps (J=K=0):
    - 0: 1 0 0 0 -> 0 1
    - 1: 0 1 0 0 -> 1 0
    - 2: 0 0 0 0 -> 1 1 (both asserted; both outputs high)
    - 3: 1 0 0 0 -> 0 1
  - Synchronous steps (Set_N=Rst_N=1), listed as step: J K -> Q (Qn = ~Q):
    - 4: 10->1, 5: 00->1, 6: 01->0, 7: 00->0
    - 8: 11->1, 9: 11->0, 10: 11->1, 11: 01->0
    - 12: 10->1, 13: 10->1, 14: 11->0, 15: 00->0
- The expected values are produced by a registered JK reference model: preset/clear override, otherwise Q_next = J&~Q | ~K&Q, updated on the LOW entry. The model must match the table.

## Timing
- Reset values:
  - Dut_Set_N=1, Dut_Rst_N=1, Dut_Clk_N=1, Dut_J=0, Dut_K=0.
  - Busy=0, Done=0, Pass=0, Err_Cnt=0, Fail_Step=0.
  - The FSM is in IDLE.
- Busy rises one cycle after Start is sampled.
- Each step is exactly 2*CLK_DIV cycles. Done asserts 32*CLK_DIV+1 cycles after the Start cycle.
- Vectors change only on HIGH entry, so J, K, Set_N and Rst_N are stable for CLK_DIV cycles before and after each falling Dut_Clk_N.
- Start asserted while Busy=1 or during FINISH is ignored; it is not queued.
- Rst asserted mid-run aborts immediately to reset values. No Done pulse is produced and Pass=0.
- Err_Cnt cannot exceed 16 and does not wrap.

## Test plan
- CLK_DIV=4 with a correct 74HC112 behavioural model, one Start -> Done at cycle 129 after Start, Pass=1, Err_Cnt=0, Fail_Step=0.
- Model with Q stuck at 0 and Qn correct -> Err_Cnt=8, Fail_Step=1, Pass=0.
- Model whose K is ignored (treated as 0) -> first mismatch at step 6: Fail_Step=6, Pass=0, Err_Cnt nonzero.
- CLK_DIV=2: check each step is 4 cycles, Dut_Clk_N falls exactly once per step, and the vector is constant for 2 cycles either side of the fall.
- Rst pulsed at step 7 -> all outputs return to reset values within the pulse, no Done; a subsequent Start runs the full sequence and yields Pass=1.
- Second Start pulsed while Busy -> ignored; Done occurs exactly once, at the original time.
